control_unit_mc: RTL and testbench
==================================

Name: control_unit_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle control unit.
- Fetches one instruction word per handshake and sequences it through FETCH/DECODE/EXECUTE/MEM/WB.
- Drives ALU select, register-file, memory and PC control strobes, plus a retired-instruction counter.
- Sits between the instruction source and the datapath (ALU, register file, data memory, PC).

Parameters:
- INSTR_W, 16, instruction word width.
- REG_ADDR_W, 4, register address field width. Constraint: IMM_W = INSTR_W-4-2*REG_ADDR_W, and IMM_W must be at least 1.
- ALU_SEL_W, 3, width of s_alu. Must be at least 3.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- instr  in  INSTR_W  instruction word.
- instr_valid  in  1  instr is valid.
- instr_ready  out  1  unit is in FETCH and can accept instr.
- mem_ack  in  1  data memory has completed the access.
- s_alu  out  ALU_SEL_W  ALU operation select.
- alu_src_imm  out  1  ALU B operand is imm, not rt.
- rd, rs, rt  out  REG_ADDR_W each  register fields from IR.
- imm  out  IMM_W  immediate / jump target field from IR.
- reg_we  out  1  register-file write strobe.
- mem_re, mem_we  out  1 each  data-memory read / write request.
- pc_inc  out  1  PC increment strobe.
- pc_load  out  1  PC load-from-imm strobe.
- halted  out  1  unit is in HALT.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Field layout of IR, MSB first: opcode[4], rd, rs, then the low REG_ADDR_W bits are rt; imm is the low IMM_W bits (imm overlaps rt).
- Opcodes:
  - 0x0 NOP.
  - 0x1-0x7 ALU register op; s_alu = opcode[2:0], zero-extended to ALU_SEL_W.
  - 0x8-0xB ALU immediate op; s_alu = {opcode[1:0]} zero-extended, alu_src_imm = 1.
  - 0xC LOAD, 0xD STORE, 0xE JUMP, 0xF HALT.
- Reset (asynchronous, immediate):
  - state = FETCH, IR = 0, retired = 0.
  - Every strobe (reg_we, mem_re, mem_we, pc_inc, pc_load, alu_src_imm) = 0; s_alu = 0; halted = 0.
  - rd, rs, rt and imm read 0.
- All control outputs are Moore outputs decoded from the registered state and IR. There are no combinational paths from inputs to outputs, except that instr_ready equals (state == FETCH).
- FETCH:
  - instr_ready = 1.
  - On instr_valid: IR <= instr and go to DECODE. Otherwise stay.
- DECODE: one cycle, no strobes. LOAD and STORE go to MEM; all other opcodes go to EXECUTE.
- EXECUTE: one cycle, then FETCH (HALT opcode goes to HALT instead).
  - ALU op: reg_we = 1, s_alu and alu_src_imm valid, pc_inc = 1.
  - NOP: pc_inc = 1 only.
  - JUMP: pc_load = 1, pc_inc = 0.
  - HALT: no strobes.
- MEM:
  - mem_re (LOAD) or mem_we (STORE) is held high until mem_ack is sampled high.
  - On mem_ack go to WB. No timeout.
- WB: one cycle, then FETCH.
  - LOAD: reg_we = 1, pc_inc = 1.
  - STORE: pc_inc = 1 only.
- HALT: halted = 1, instr_ready = 0. Terminal until reset.
- retired increments by 1 on the final cycle of every instruction (EXECUTE or WB), including HALT's EXECUTE cycle. It wraps modulo 2^CNT_W.
- Latency in clock edges from the FETCH handshake edge:
  - ALU, NOP and JUMP instructions take 3 edges.
  - LOAD and STORE take 3 + N edges, where N is the number of MEM cycles (at least 1).
- Ignored inputs:
  - instr_valid is ignored outside FETCH.
  - mem_ack is ignored outside MEM.
  - mem_ack already high on MEM entry completes MEM in 1 cycle.
- Reset asserted mid-MEM drops mem_re/mem_we immediately. The in-flight instruction is not counted.
- At most one of reg_we/mem_we and at most one of pc_inc/pc_load is high in any cycle.

Test Plan:
- Reset, then apply instr = 0x3D00 with instr_valid held high.
  - Required: instr_ready=1 in FETCH, then DECODE, then EXECUTE.
  - In EXECUTE: s_alu=3, rd=0xD, reg_we=1, pc_inc=1, alu_src_imm=0.
  - Then back to FETCH with retired=1.
- Apply instr = 0x9A05.
  - Required in EXECUTE: s_alu=1, alu_src_imm=1, imm=0x5, rd=0xA, reg_we=1.
- Apply LOAD 0xC120 with mem_ack delayed 3 cycles.
  - Required: mem_re high for exactly 3 cycles.
  - Then WB with reg_we=1, rd=1, pc_inc=1.
  - Total 6 edges from handshake; retired increments once.
- Apply JUMP 0xE0F7.
  - Required: pc_load=1, imm=0x7, pc_inc=0 for exactly one cycle.
- Apply HALT 0xFD0F, then pulse instr_valid repeatedly.
  - Required: halted=1, instr_ready stays 0, retired frozen.
  - After reset_n low: halted=0, retired=0.
- With CNT_W=2, retire 5 NOPs.
  - Required: retired sequence 1,2,3,0,1.
- Issue STORE, then assert reset_n low during MEM.
  - Required: mem_we falls without waiting for a clock edge; state returns to FETCH; retired is unchanged from its pre-STORE value.

Source files
------------

// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencer
// with Moore-decoded datapath strobes and a retired-instruction counter.
module control_unit_mc #(
   parameter  int INSTR_W    = 16,
   parameter  int REG_ADDR_W = 4,
   parameter  int ALU_SEL_W  = 3,
   parameter  int CNT_W      = 16,
   localparam int IMM_W      = INSTR_W - 4 - 2 * REG_ADDR_W
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [INSTR_W-1:0]    instr,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic                  mem_ack,
   output logic [ALU_SEL_W-1:0]  s_alu,
   output logic                  alu_src_imm,
   output logic [REG_ADDR_W-1:0] rd,
   output logic [REG_ADDR_W-1:0] rs,
   output logic [REG_ADDR_W-1:0] rt,
   output logic [IMM_W-1:0]      imm,
   output logic                  reg_we,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic                  pc_inc,
   output logic                  pc_load,
   output logic                  halted,
   output logic [CNT_W-1:0]      retired
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [INSTR_W-1:0] r_ir;
   logic [CNT_W-1:0]   r_retired;
   logic [3:0]         w_op;
   logic               w_alu_r;
   logic               w_alu_i;
   logic               w_nop;
   logic               w_load;
   logic               w_store;
   logic               w_jump;
   logic               w_halt;

   assign w_op    = r_ir[INSTR_W-1 -: 4];
   assign w_nop   = (w_op == 4'h0);
   assign w_alu_r = (w_op[3] == 1'b0) && !w_nop;
   assign w_alu_i = (w_op[3:2] == 2'b10);
   assign w_load  = (w_op == 4'hC);
   assign w_store = (w_op == 4'hD);
   assign w_jump  = (w_op == 4'hE);
   assign w_halt  = (w_op == 4'hF);

   assign rd      = r_ir[INSTR_W-5 -: REG_ADDR_W];
   assign rs      = r_ir[INSTR_W-5-REG_ADDR_W -: REG_ADDR_W];
   assign rt      = r_ir[REG_ADDR_W-1:0];
   assign imm     = r_ir[IMM_W-1:0];
   assign retired = r_retired;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_FETCH;
      else          r_state <= w_next;
   end

   // Instruction register, loaded on the fetch handshake
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_ir <= '0;
      else if (r_state == S_FETCH && instr_valid)
         r_ir <= instr;
   end

   // Retire count: bumps on the last cycle of each instruction
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_retired <= '0;
      else if (r_state == S_EXEC || r_state == S_WB)
         r_retired <= r_retired + CNT_W'(1);
   end

   // Next-state and Moore output decode
   always_comb begin
      w_next      = r_state;
      instr_ready = 1'b0;
      s_alu       = '0;
      alu_src_imm = 1'b0;
      reg_we      = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      halted      = 1'b0;
      unique case (r_state)
         S_FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) w_next = S_DECODE;
         end
         S_DECODE: begin
            if (w_load || w_store) w_next = S_MEM;
            else                   w_next = S_EXEC;
         end
         S_EXEC: begin
            w_next = w_halt ? S_HALT : S_FETCH;
            if (w_alu_r) begin
               s_alu[2:0] = w_op[2:0];
               reg_we     = 1'b1;
               pc_inc     = 1'b1;
            end
            if (w_alu_i) begin
               s_alu[1:0]  = w_op[1:0];
               alu_src_imm = 1'b1;
               reg_we      = 1'b1;
               pc_inc      = 1'b1;
            end
            if (w_nop)  pc_inc  = 1'b1;
            if (w_jump) pc_load = 1'b1;
         end
         S_MEM: begin
            mem_re = w_load;
            mem_we = w_store;
            if (mem_ack) w_next = S_WB;
         end
         S_WB: begin
            reg_we = w_load;
            pc_inc = 1'b1;
            w_next = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: vector table for single-cycle
// execute ops plus hand sequences for MEM, HALT, wrap and reset.
module tb_control_unit_mc;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [15:0] instr;
   logic        instr_valid;
   logic        mem_ack;

   logic        instr_ready;
   logic [2:0]  s_alu;
   logic        alu_src_imm;
   logic [3:0]  rd, rs, rt, imm;
   logic        reg_we, mem_re, mem_we, pc_inc, pc_load, halted;
   logic [15:0] retired;

   logic        b_instr_ready;
   logic [2:0]  b_s_alu;
   logic        b_alu_src_imm;
   logic [3:0]  b_rd, b_rs, b_rt, b_imm;
   logic        b_reg_we, b_mem_re, b_mem_we;
   logic        b_pc_inc, b_pc_load, b_halted;
   logic [1:0]  b_retired;

   int n_chk = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   control_unit_mc dut (
      .clock(clock), .reset_n(reset_n),
      .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .mem_ack(mem_ack),
      .s_alu(s_alu), .alu_src_imm(alu_src_imm),
      .rd(rd), .rs(rs), .rt(rt), .imm(imm),
      .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
      .pc_inc(pc_inc), .pc_load(pc_load),
      .halted(halted), .retired(retired)
   );

   control_unit_mc #(.CNT_W(2)) dut_w (
      .clock(clock), .reset_n(reset_n),
      .instr(instr), .instr_valid(instr_valid),
      .instr_ready(b_instr_ready), .mem_ack(mem_ack),
      .s_alu(b_s_alu), .alu_src_imm(b_alu_src_imm),
      .rd(b_rd), .rs(b_rs), .rt(b_rt), .imm(b_imm),
      .reg_we(b_reg_we), .mem_re(b_mem_re), .mem_we(b_mem_we),
      .pc_inc(b_pc_inc), .pc_load(b_pc_load),
      .halted(b_halted), .retired(b_retired)
   );

   typedef struct {
      logic [15:0] instr;
      logic        alu;
      logic [2:0]  s_alu;
      logic        src;
      logic [3:0]  rd;
      logic [3:0]  imm;
      logic [2:0]  str;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // {reg_we, mem_re, mem_we, pc_inc, pc_load, alu_src_imm, halted}
   function automatic logic [6:0] strobes();
      return {reg_we, mem_re, mem_we, pc_inc, pc_load,
              alu_src_imm, halted};
   endfunction

   task automatic do_reset();
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_ready", {31'd0, instr_ready}, 32'd1);
      chk("rst_strobes", {25'd0, strobes()}, 32'd0);
      chk("rst_fields", {16'd0, rd, rs, rt, imm}, 32'd0);
      chk("rst_retired", {16'd0, retired}, 32'd0);
      chk("rst_s_alu", {29'd0, s_alu}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [15:0] r0;
      logic [1:0]  wrap_exp[5];

      reset_n     = 1'b1;
      instr       = '0;
      instr_valid = 1'b0;
      mem_ack     = 1'b0;

      vt[0] = '{16'h3D00, 1'b1, 3'd3, 1'b0, 4'hD, 4'h0, 3'b110};
      vt[1] = '{16'h9A05, 1'b1, 3'd1, 1'b1, 4'hA, 4'h5, 3'b110};
      vt[2] = '{16'h0123, 1'b0, 3'd0, 1'b0, 4'h1, 4'h3, 3'b010};
      vt[3] = '{16'hE0F7, 1'b0, 3'd0, 1'b0, 4'h0, 4'h7, 3'b001};
      vt[4] = '{16'hB456, 1'b1, 3'd3, 1'b1, 4'h4, 4'h6, 3'b110};
      vt[5] = '{16'h7FFF, 1'b1, 3'd7, 1'b0, 4'hF, 4'hF, 3'b110};
      wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      do_reset();

      // Single-cycle EXECUTE instructions from the table
      for (int i = 0; i < 6; i++) begin
         r0 = retired;
         instr = vt[i].instr;
         instr_valid = 1'b1;
         chk("fetch_ready", {31'd0, instr_ready}, 32'd1);
         tick();
         chk("dec_ready", {31'd0, instr_ready}, 32'd0);
         chk("dec_strobes", {25'd0, strobes()}, 32'd0);
         tick();
         instr_valid = 1'b0;
         chk("ex_rd", {28'd0, rd}, {28'd0, vt[i].rd});
         chk("ex_imm", {28'd0, imm}, {28'd0, vt[i].imm});
         chk("ex_src", {31'd0, alu_src_imm}, {31'd0, vt[i].src});
         chk("ex_str", {29'd0, reg_we, pc_inc, pc_load},
             {29'd0, vt[i].str});
         chk("ex_mem", {30'd0, mem_re, mem_we}, 32'd0);
         if (vt[i].alu)
            chk("ex_s_alu", {29'd0, s_alu}, {29'd0, vt[i].s_alu});
         tick();
         chk("done_ready", {31'd0, instr_ready}, 32'd1);
         chk("done_pc", {30'd0, pc_inc, pc_load}, 32'd0);
         chk("done_retired", {16'd0, retired}, {16'd0, r0 + 16'd1});
      end

      // LOAD with mem_ack after three MEM cycles
      r0 = retired;
      instr = 16'hC120;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      chk("ld_dec_re", {31'd0, mem_re}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("ld_mem_re", {31'd0, mem_re}, 32'd1);
         chk("ld_mem_oth", {30'd0, mem_we, reg_we}, 32'd0);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("ld_wb_re", {31'd0, mem_re}, 32'd0);
      chk("ld_wb", {27'd0, reg_we, pc_inc, rd}, {27'd0, 2'b11, 4'h1});
      chk("ld_wb_ret", {16'd0, retired}, {16'd0, r0});
      tick();
      chk("ld_ready", {31'd0, instr_ready}, 32'd1);
      chk("ld_retired", {16'd0, retired}, {16'd0, r0 + 16'd1});

      // STORE with mem_ack already high: one MEM cycle
      r0 = retired;
      mem_ack = 1'b1;
      instr = 16'hD234;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      chk("st_dec", {31'd0, mem_we}, 32'd0);
      tick();
      chk("st_mem", {25'd0, strobes()}, 32'b0010000);
      tick();
      mem_ack = 1'b0;
      chk("st_wb", {25'd0, strobes()}, 32'b0001000);
      tick();
      chk("st_ready", {31'd0, instr_ready}, 32'd1);
      chk("st_retired", {16'd0, retired}, {16'd0, r0 + 16'd1});

      // HALT, then repeated instr_valid pulses are ignored
      r0 = retired;
      instr = 16'hFD0F;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      chk("hlt_ex", {25'd0, strobes()}, 32'd0);
      tick();
      chk("hlt_on", {30'd0, halted, instr_ready}, 32'b10);
      chk("hlt_ret", {16'd0, retired}, {16'd0, r0 + 16'd1});
      instr = 16'h3D00;
      for (int c = 0; c < 4; c++) begin
         instr_valid = (c % 2 == 0);
         tick();
         chk("hlt_stay", {30'd0, halted, instr_ready}, 32'b10);
         chk("hlt_frz", {16'd0, retired}, {16'd0, r0 + 16'd1});
      end
      instr_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("hlt_rst", {30'd0, halted, instr_ready}, 32'b01);
      chk("hlt_rst_ret", {16'd0, retired}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // Counter wrap on the CNT_W=2 instance
      for (int i = 0; i < 5; i++) begin
         instr = 16'h0000;
         instr_valid = 1'b1;
         tick();
         instr_valid = 1'b0;
         tick();
         tick();
         chk("wrap_cnt", {30'd0, b_retired}, {30'd0, wrap_exp[i]});
         chk("wide_cnt", {16'd0, retired}, i + 1);
      end

      // Reset during a STORE's MEM wait
      do_reset();
      r0 = retired;
      instr = 16'hD234;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      chk("strst_we", {31'd0, mem_we}, 32'd1);
      tick();
      chk("strst_hold", {31'd0, mem_we}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("strst_drop", {31'd0, mem_we}, 32'd0);
      chk("strst_fetch", {31'd0, instr_ready}, 32'd1);
      chk("strst_ret", {16'd0, retired}, {16'd0, r0});
      tick();
      reset_n = 1'b1;
      tick();
      chk("strst_idle", {25'd0, strobes()}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
